// File: rtl/conv_idx_seq_pkg.sv
// Shared types and helpers for the 1-D convolution index sequencer.
package conv_pkg;

  localparam int CONV_AW = 5;
  localparam int CONV_ZW = 6;
  localparam int MAX_LEN = 2 ** CONV_AW;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    CALC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic [CONV_ZW-1:0] sat_size(input logic [CONV_ZW-1:0] sz);
    if (sz > CONV_ZW'(MAX_LEN)) begin
      return CONV_ZW'(MAX_LEN);
    end else begin
      return sz;
    end
  endfunction

endpackage

// File: rtl/conv_idx_seq_idx_counter.sv
// Up-counter with synchronous clear/increment, exposing its next value
// so the parent can register outputs decoded from the upcoming count.
module idx_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_nxt_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;
  assign last_o    = (cnt_q == last_i);

endmodule

// File: rtl/conv_idx_seq.sv
// Index sequencer for Z = X * Y: walks output index i and inner index j and
// drives pointer, memory-address, accumulator and Z-write controls.
module conv_idx_seq
  import conv_pkg::*;
#(
  parameter int AW = CONV_AW,
  parameter int ZW = CONV_ZW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start_i,
  input  logic [ZW-1:0] size_x_i,
  input  logic [ZW-1:0] size_y_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [ZW-1:0] ptr_nxt_o,
  output logic          ptr_en_o,
  output logic          ptr_clr_o,
  output logic [AW-1:0] x_addr_o,
  output logic [AW-1:0] y_addr_o,
  output logic          acc_en_o,
  output logic          acc_clr_o,
  output logic [ZW-1:0] z_addr_o,
  output logic          z_we_o
);

  state_t        state_q, state_d;
  logic [ZW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [ZW-1:0] i_q, i_d, j_q, j_d;
  logic [ZW-1:0] i_last, j_last;
  logic          i_clr, i_inc, i_term;
  logic          j_clr, j_inc, j_term;

  // Lz-1 = sx+sy-2 stays below 2**ZW, so modular ZW-bit arithmetic is exact
  assign i_last = sx_q + sy_q - ZW'(2);
  assign j_last = sy_q - ZW'(1);

  idx_counter #(.W(ZW)) u_i_cnt (
    .clk       (clk),
    .rstn      (rstn),
    .clr_i     (i_clr),
    .inc_i     (i_inc),
    .last_i    (i_last),
    .cnt_o     (i_q),
    .cnt_nxt_o (i_d),
    .last_o    (i_term)
  );

  idx_counter #(.W(ZW)) u_j_cnt (
    .clk       (clk),
    .rstn      (rstn),
    .clr_i     (j_clr),
    .inc_i     (j_inc),
    .last_i    (j_last),
    .cnt_o     (j_q),
    .cnt_nxt_o (j_d),
    .last_o    (j_term)
  );

  // next state, size latch and counter control
  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    i_clr   = 1'b1;
    i_inc   = 1'b0;
    j_clr   = 1'b1;
    j_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          sx_d = sat_size(size_x_i);
          sy_d = sat_size(size_y_i);
          if ((sx_d == {ZW{1'b0}}) || (sy_d == {ZW{1'b0}})) begin
            state_d = DONE;
          end else begin
            state_d = INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      INIT: state_d = CALC;
      CALC: begin
        i_clr   = 1'b0;
        j_clr   = 1'b0;
        j_inc   = !j_term;
        state_d = j_term ? WRITE : CALC;
      end
      WRITE: begin
        i_clr   = 1'b0;
        i_inc   = !i_term;
        state_d = i_term ? DONE : CALC;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [ZW:0]   diff_d;
  logic          valid_d;
  logic          busy_d, done_d, ptr_en_d, ptr_clr_d, acc_en_d, acc_clr_d, z_we_d;
  logic [ZW-1:0] ptr_nxt_d, z_addr_d;
  logic [AW-1:0] x_addr_d, y_addr_d;

  // i - j kept one bit wider so an underflow reads as invalid, not as a large index
  assign diff_d  = {1'b0, i_d} - {1'b0, j_d};
  assign valid_d = (i_d >= j_d) && (diff_d < {1'b0, sx_d});

  // Moore decode of the upcoming state so outputs leave registers aligned with it
  always_comb begin
    busy_d    = (state_d != IDLE);
    done_d    = 1'b0;
    ptr_nxt_d = {ZW{1'b0}};
    ptr_en_d  = 1'b0;
    ptr_clr_d = 1'b0;
    x_addr_d  = {AW{1'b0}};
    y_addr_d  = {AW{1'b0}};
    acc_en_d  = 1'b0;
    acc_clr_d = 1'b0;
    z_addr_d  = {ZW{1'b0}};
    z_we_d    = 1'b0;
    case (state_d)
      INIT: begin
        ptr_clr_d = 1'b1;
        acc_clr_d = 1'b1;
      end
      CALC: begin
        ptr_nxt_d = diff_d[ZW-1:0];
        x_addr_d  = diff_d[AW-1:0];
        y_addr_d  = j_d[AW-1:0];
        ptr_en_d  = valid_d;
        acc_en_d  = valid_d;
      end
      WRITE: begin
        z_addr_d  = i_d;
        z_we_d    = 1'b1;
        acc_clr_d = 1'b1;
        ptr_clr_d = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: busy_d = (state_d != IDLE);
    endcase
  end

  // state, latched sizes and registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      sx_q      <= {ZW{1'b0}};
      sy_q      <= {ZW{1'b0}};
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      ptr_nxt_o <= {ZW{1'b0}};
      ptr_en_o  <= 1'b0;
      ptr_clr_o <= 1'b0;
      x_addr_o  <= {AW{1'b0}};
      y_addr_o  <= {AW{1'b0}};
      acc_en_o  <= 1'b0;
      acc_clr_o <= 1'b0;
      z_addr_o  <= {ZW{1'b0}};
      z_we_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      busy_o    <= busy_d;
      done_o    <= done_d;
      ptr_nxt_o <= ptr_nxt_d;
      ptr_en_o  <= ptr_en_d;
      ptr_clr_o <= ptr_clr_d;
      x_addr_o  <= x_addr_d;
      y_addr_o  <= y_addr_d;
      acc_en_o  <= acc_en_d;
      acc_clr_o <= acc_clr_d;
      z_addr_o  <= z_addr_d;
      z_we_o    <= z_we_d;
    end
  end

endmodule

// File: tb/tb_conv_idx_seq.sv
// Directed bench for conv_idx_seq: runs jobs, logs per-cycle activity and
// compares against hand-computed sequences and latencies.
module tb_conv_idx_seq;

  localparam int AW = 5;
  localparam int ZW = 6;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start_i = 1'b0;
  logic [ZW-1:0] size_x_i = '0;
  logic [ZW-1:0] size_y_i = '0;
  logic          busy_o, done_o, ptr_en_o, ptr_clr_o, acc_en_o, acc_clr_o, z_we_o;
  logic [ZW-1:0] ptr_nxt_o, z_addr_o;
  logic [AW-1:0] x_addr_o, y_addr_o;

  conv_idx_seq #(.AW(AW), .ZW(ZW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start_i   (start_i),
    .size_x_i  (size_x_i),
    .size_y_i  (size_y_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .ptr_nxt_o (ptr_nxt_o),
    .ptr_en_o  (ptr_en_o),
    .ptr_clr_o (ptr_clr_o),
    .x_addr_o  (x_addr_o),
    .y_addr_o  (y_addr_o),
    .acc_en_o  (acc_en_o),
    .acc_clr_o (acc_clr_o),
    .z_addr_o  (z_addr_o),
    .z_we_o    (z_we_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {3'b000, busy_o, done_o, ptr_nxt_o, ptr_en_o, ptr_clr_o, x_addr_o,
            y_addr_o, acc_en_o, acc_clr_o, z_addr_o, z_we_o};
  endfunction

  int          wq[$], xq[$], yq[$], pq[$];
  int          done_cyc, n_acc, n_pen, n_calc, en_mis;
  logic [63:0] pat;

  task automatic check_seq(input string tag, input int got[$], input int exp[$]);
    int mism;
    mism = 0;
    check_eq({tag, "_len"}, got.size(), exp.size());
    for (int k = 0; k < got.size() && k < exp.size(); k++) begin
      if (got[k] != exp[k]) mism++;
    end
    check_eq({tag, "_data"}, mism, 0);
  endtask

  // start a job; mid>0 disturbs start/sizes at that cycle, rst_at>0 pulses reset there
  task automatic run_job(input int sx, input int sy, input int mid, input int rst_at,
                         input int budget);
    wq.delete(); xq.delete(); yq.delete(); pq.delete();
    done_cyc = -1; n_acc = 0; n_pen = 0; n_calc = 0; en_mis = 0; pat = '0;
    @(negedge clk);
    start_i  = 1'b1;
    size_x_i = ZW'(sx);
    size_y_i = ZW'(sy);
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (z_we_o) wq.push_back(int'(z_addr_o));
      if (acc_en_o) begin
        n_acc++;
        xq.push_back(int'(x_addr_o));
        yq.push_back(int'(y_addr_o));
      end
      if (ptr_en_o) begin
        n_pen++;
        pq.push_back(int'(ptr_nxt_o));
      end
      if (ptr_en_o != acc_en_o) en_mis++;
      if (busy_o && !ptr_clr_o && !done_o) begin
        n_calc++;
        pat = {pat[62:0], acc_en_o};
      end
      if (rst_at == k) begin
        rstn = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_outs", outs_vec(), 32'd0);
        rstn = 1'b1;
        done_cyc = -2;
        break;
      end
      if (mid == k) begin
        start_i  = 1'b1;
        size_x_i = ZW'(7);
        size_y_i = ZW'(7);
      end
      if (done_o) begin
        done_cyc = k;
        start_i  = 1'b0;
        break;
      end
    end
    if (done_cyc == -1) check_eq("timeout_done", done_o, 32'd1);
  endtask

  initial begin
    int e[$];
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outs", outs_vec(), 32'd0);
    rstn = 1'b1;

    // 1x1
    run_job(1, 1, 0, 0, 50);
    check_eq("t1_done_cyc", done_cyc, 32'd4);
    e = {0}; check_seq("t1_z", wq, e);
    e = {0}; check_seq("t1_x", xq, e);
    e = {0}; check_seq("t1_y", yq, e);
    e = {0}; check_seq("t1_ptr", pq, e);
    check_eq("t1_pat", pat, 64'd1);

    // 3x2: Lz=4
    run_job(3, 2, 0, 0, 100);
    check_eq("t2_done_cyc", done_cyc, 32'd14);
    check_eq("t2_ncalc", n_calc, 32'd8);
    check_eq("t2_pat", pat[7:0], 32'hBD);
    e = {0, 1, 2, 3};       check_seq("t2_z", wq, e);
    e = {0, 1, 0, 2, 1, 2}; check_seq("t2_x", xq, e);
    e = {0, 0, 1, 0, 1, 1}; check_seq("t2_y", yq, e);
    e = {0, 1, 0, 2, 1, 2}; check_seq("t2_ptr", pq, e);
    check_eq("t2_en_match", en_mis, 32'd0);

    // zero size
    run_job(0, 5, 0, 0, 20);
    check_eq("t3_done_cyc", done_cyc, 32'd1);
    check_eq("t3_nwe", wq.size(), 32'd0);
    check_eq("t3_nacc", n_acc, 32'd0);
    check_eq("t3_npen", n_pen, 32'd0);

    // start and sizes changed mid-run; start held through DONE
    run_job(2, 2, 2, 0, 100);
    check_eq("t4_done_cyc", done_cyc, 32'd11);
    e = {0, 1, 2}; check_seq("t4_z", wq, e);
    check_eq("t4_nacc", n_acc, 32'd4);
    @(negedge clk);
    check_eq("t4_no_restart", busy_o, 32'd0);

    // reset during CALC of i=1, then a fresh 1x1 job
    run_job(2, 2, 0, 5, 100);
    check_eq("t5_aborted", done_cyc, 32'hFFFF_FFFE);
    run_job(1, 1, 0, 0, 50);
    check_eq("t5_done_cyc", done_cyc, 32'd4);
    e = {0}; check_seq("t5_z", wq, e);

    // saturation 40x32 -> 32x32, Lz=63
    run_job(40, 32, 0, 0, 3000);
    check_eq("t6_done_cyc", done_cyc, 32'd2081);
    e.delete();
    for (int k = 0; k < 63; k++) e.push_back(k);
    check_seq("t6_z", wq, e);
    check_eq("t6_nacc", n_acc, 32'd1024);
    check_eq("t6_en_match", en_mis, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
